// File: rtl/spi_bridge_pkg.sv
// Shared command codes, FSM states and constants for the SPI pixel bridge.
package spi_bridge_pkg;

    localparam logic [7:0] CMD_WR      = 8'h80;
    localparam logic [7:0] CMD_RD      = 8'h81;
    localparam logic [7:0] CMD_RDRES   = 8'h82;
    localparam logic [7:0] CMD_RDCNT   = 8'h83;
    localparam logic [7:0] CMD_SCR_CLR = 8'h40;
    localparam logic [7:0] CMD_SCR_SET = 8'h41;
    localparam logic [7:0] CMD_BURST   = 8'h55;

    localparam logic [7:0] FEED_IDLE   = 8'hFF;

    typedef enum logic [2:0] {
        CMD,
        ADDR,
        DATA,
        BURST,
        SKIP
    } state_e;

endpackage

// File: rtl/spi_byte_packer.sv
// Packs burst bytes MSB-first into PIX_BYTES-wide pixels with a one-cycle valid pulse.
module spi_byte_packer #(
    parameter int unsigned PIX_BYTES = 6
) (
    input  logic                   clk_p,
    input  logic                   rst_p,
    input  logic                   clr_i,
    input  logic                   byte_vld_i,
    input  logic [7:0]             byte_i,
    output logic [PIX_BYTES*8-1:0] pix_o,
    output logic                   pix_vld_o
);

    localparam int unsigned PIX_W = PIX_BYTES * 8;
    localparam int unsigned BC_W  = (PIX_BYTES > 1) ? $clog2(PIX_BYTES) : 1;

    logic [BC_W-1:0]  bcnt_q, bcnt_d;
    logic [PIX_W-1:0] shift_q, shift_d;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic             vld_q, vld_d;
    logic             last_c;

    always_comb begin
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        pix_d   = pix_q;
        vld_d   = 1'b0;
        last_c  = (bcnt_q == BC_W'(PIX_BYTES - 1));
        if (clr_i) begin
            bcnt_d  = '0;
            shift_d = '0;
        end else if (byte_vld_i) begin
            // Keep only the newest PIX_BYTES bytes; the oldest ends up in the MSB byte.
            shift_d = PIX_W'({shift_q, byte_i});
            if (last_c) begin
                bcnt_d = '0;
                pix_d  = shift_d;
                vld_d  = 1'b1;
            end else begin
                bcnt_d = bcnt_q + BC_W'(1);
            end
        end
    end

    always_ff @(posedge clk_p) begin
        if (rst_p) begin
            bcnt_q  <= '0;
            shift_q <= '0;
            pix_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            pix_q   <= pix_d;
            vld_q   <= vld_d;
        end
    end

    assign pix_o     = pix_q;
    assign pix_vld_o = vld_q;

endmodule

// File: rtl/spi_pixel_bridge.sv
// SPI command decoder, register file and burst pixel streamer between the SPI byte
// interface and the vision pipeline.
module spi_pixel_bridge
    import spi_bridge_pkg::*;
#(
    parameter int unsigned REG_N     = 8,
    parameter int unsigned PIX_BYTES = 6,
    parameter int unsigned RES_N     = 9,
    parameter int unsigned CNT_W     = 20
) (
    input  logic                   clk_p,
    input  logic                   rst_p,
    input  logic                   css_i,
    input  logic                   byte_vld_i,
    input  logic [7:0]             byte_i,
    output logic [7:0]             feed_o,
    input  logic [RES_N*8-1:0]     res_i,
    output logic [REG_N*8-1:0]     regs_o,
    output logic [PIX_BYTES*8-1:0] pix_o,
    output logic                   pix_vld_o,
    output logic                   scr_rst_o,
    output logic                   burst_o,
    output logic                   ovr_o
);

    localparam int unsigned EXT_W = 24;

    state_e             state_q, state_d;
    logic [7:0]         cmd_q, cmd_d;
    logic [7:0]         addr_q, addr_d;
    logic [7:0]         feed_q, feed_d;
    logic [REG_N*8-1:0] regs_q, regs_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               scr_q, scr_d;
    logic               burst_q, burst_d;
    logic               ovr_q, ovr_d;
    logic               acc_c;
    logic               burst_byte_c;
    logic [EXT_W-1:0]   cnt_ext_c;

    // A byte only counts while the frame is selected.
    assign acc_c     = css_i & byte_vld_i;
    assign cnt_ext_c = EXT_W'(cnt_q);

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        feed_d       = feed_q;
        regs_d       = regs_q;
        cnt_d        = cnt_q;
        scr_d        = scr_q;
        ovr_d        = ovr_q;
        burst_byte_c = 1'b0;

        if (pix_vld_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (acc_c && pix_vld_o) begin
            ovr_d = 1'b1;
        end

        if (!css_i) begin
            state_d = CMD;
            feed_d  = FEED_IDLE;
        end else if (acc_c) begin
            feed_d = FEED_IDLE;
            case (state_q)
                CMD: begin
                    cmd_d = byte_i;
                    case (byte_i)
                        CMD_WR, CMD_RD, CMD_RDRES, CMD_RDCNT: state_d = ADDR;
                        CMD_BURST: state_d = BURST;
                        CMD_SCR_CLR: begin
                            scr_d   = 1'b0;
                            state_d = SKIP;
                        end
                        CMD_SCR_SET: begin
                            scr_d   = 1'b1;
                            cnt_d   = '0;
                            ovr_d   = 1'b0;
                            state_d = SKIP;
                        end
                        default: state_d = SKIP;
                    endcase
                end
                ADDR: begin
                    addr_d  = byte_i;
                    state_d = (cmd_q == CMD_WR) ? DATA : SKIP;
                    case (cmd_q)
                        CMD_RD:
                            feed_d = (32'(byte_i) < REG_N) ? regs_q[32'(byte_i)*8 +: 8] : 8'h00;
                        CMD_RDRES:
                            feed_d = (32'(byte_i) < RES_N) ? res_i[32'(byte_i)*8 +: 8] : 8'h00;
                        CMD_RDCNT: begin
                            case (byte_i)
                                8'd0:    feed_d = cnt_ext_c[7:0];
                                8'd1:    feed_d = cnt_ext_c[15:8];
                                8'd2:    feed_d = cnt_ext_c[23:16];
                                default: feed_d = 8'h00;
                            endcase
                        end
                        default: feed_d = FEED_IDLE;
                    endcase
                end
                DATA: begin
                    if (32'(addr_q) < REG_N) begin
                        regs_d[32'(addr_q)*8 +: 8] = byte_i;
                    end
                    state_d = SKIP;
                end
                BURST: begin
                    burst_byte_c = 1'b1;
                    feed_d = (32'(regs_q[7:0]) < RES_N) ? res_i[32'(regs_q[7:0])*8 +: 8] : 8'h00;
                end
                SKIP:    state_d = SKIP;
                default: state_d = CMD;
            endcase
        end

        burst_d = (state_d == BURST);
    end

    always_ff @(posedge clk_p) begin
        if (rst_p) begin
            state_q <= CMD;
            cmd_q   <= '0;
            addr_q  <= '0;
            feed_q  <= FEED_IDLE;
            regs_q  <= '0;
            cnt_q   <= '0;
            scr_q   <= 1'b0;
            burst_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            feed_q  <= feed_d;
            regs_q  <= regs_d;
            cnt_q   <= cnt_d;
            scr_q   <= scr_d;
            burst_q <= burst_d;
            ovr_q   <= ovr_d;
        end
    end

    spi_byte_packer #(
        .PIX_BYTES(PIX_BYTES)
    ) u_packer (
        .clk_p     (clk_p),
        .rst_p     (rst_p),
        .clr_i     (~css_i),
        .byte_vld_i(burst_byte_c),
        .byte_i    (byte_i),
        .pix_o     (pix_o),
        .pix_vld_o (pix_vld_o)
    );

    assign feed_o    = feed_q;
    assign regs_o    = regs_q;
    assign scr_rst_o = scr_q;
    assign burst_o   = burst_q;
    assign ovr_o     = ovr_q;

endmodule
